arc4_param: RTL and testbench



---
 rtl/arc4_pkg.sv | 28 ++
 rtl/arc4_sbox.sv | 22 ++
 rtl/arc4_param.sv | 259 +++++++++++++++++++++++++
 tb/tb_arc4_param.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arc4_pkg.sv
// ARC4 shared definitions: FSM state codes, S-box depth,
// per-phase cycle counts and a run-length helper.
package arc4_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_INIT = 3'd1;
  localparam state_t ST_KSA  = 3'd2;
  localparam state_t ST_LEN  = 3'd3;
  localparam state_t ST_DROP = 3'd4;
  localparam state_t ST_PRGA = 3'd5;
  localparam state_t ST_DONE = 3'd6;

  localparam int SBOX_DEPTH  = 256;
  localparam int INIT_CYCLES = 256;
  localparam int KSA_STEPS   = 6;
  localparam int LEN_CYCLES  = 2;
  localparam int DROP_STEPS  = 6;
  localparam int PRGA_STEPS  = 9;
  localparam int DONE_CYCLES = 1;

  function automatic int run_cycles(input int drop_n, input int len);
    return INIT_CYCLES + SBOX_DEPTH * KSA_STEPS + LEN_CYCLES
         + DROP_STEPS * drop_n + PRGA_STEPS * len + DONE_CYCLES;
  endfunction

endpackage

// File: rtl/arc4_sbox.sv
// ARC4 state array: 256x8, registered read port,
// independent write port, contents never reset.
module arc4_sbox
  import arc4_pkg::*;
(
  input  logic       clk,
  input  logic [7:0] raddr,
  output logic [7:0] rddata,
  input  logic       we,
  input  logic [7:0] waddr,
  input  logic [7:0] wdata
);

  logic [7:0] mem [SBOX_DEPTH];

  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
    rddata <= mem[raddr];
  end

endmodule

// File: rtl/arc4_param.sv
// ARC4 (optionally RC4-drop[N]) decryptor: builds S from key,
// then streams ct[1..L] into pt[1..L] with pt[0]=L.
module arc4_param
  import arc4_pkg::*;
#(
  parameter int KEY_BYTES = 3,
  parameter int DROP_N    = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  output logic                   rdy,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic [7:0]             ct_addr,
  input  logic [7:0]             ct_rddata,
  output logic [7:0]             pt_addr,
  input  logic [7:0]             pt_rddata,
  output logic [7:0]             pt_wrdata,
  output logic                   pt_wren
);

  localparam int KW = 8 * KEY_BYTES;

  if (KEY_BYTES < 1 || KEY_BYTES > 32) begin : g_bad_key
    $error("arc4_param: KEY_BYTES must be 1..32");
  end
  if (DROP_N < 0 || DROP_N > 4095) begin : g_bad_drop
    $error("arc4_param: DROP_N must be 0..4095");
  end

  localparam logic [4:0]  KEY_LAST  = 5'(KEY_BYTES - 1);
  localparam logic [11:0] DROP_LAST = 12'((DROP_N > 0) ? DROP_N - 1 : 0);
  localparam logic [3:0]  KSA_LAST  = 4'(KSA_STEPS - 1);
  localparam logic [3:0]  DRP_LAST  = 4'(DROP_STEPS - 1);
  localparam logic [3:0]  PRG_LAST  = 4'(PRGA_STEPS - 1);

  state_t      state;
  logic [3:0]  step;
  logic [7:0]  i, j, k, len, si, sj;
  logic [4:0]  kidx;
  logic [11:0] dcnt;
  logic [KW-1:0] key_r;

  logic [7:0] sb_raddr, sb_rd, sb_waddr, sb_wdata;
  logic       sb_we;
  logic [7:0] key_arr [32];
  logic [7:0] kb;

  logic unused_pt;
  assign unused_pt = ^pt_rddata;

  arc4_sbox u_sbox (
    .clk    (clk),
    .raddr  (sb_raddr),
    .rddata (sb_rd),
    .we     (sb_we),
    .waddr  (sb_waddr),
    .wdata  (sb_wdata)
  );

  // Byte 0 of the key lives in the top bits.
  always_comb begin
    for (int b = 0; b < 32; b++)
      key_arr[b] = '0;
    for (int b = 0; b < KEY_BYTES; b++)
      key_arr[b] = key_r[KW-1-8*b -: 8];
  end

  assign kb  = key_arr[kidx];
  assign rdy = (state == ST_IDLE);

  logic st_init, st_swap, st_len, st_prga;
  assign st_init = (state == ST_INIT);
  assign st_swap = (state == ST_KSA) || (state == ST_DROP);
  assign st_len  = (state == ST_LEN);
  assign st_prga = (state == ST_PRGA);

  always_comb begin
    sb_raddr  = '0;
    sb_we     = 1'b0;
    sb_waddr  = '0;
    sb_wdata  = '0;
    ct_addr   = '0;
    pt_addr   = '0;
    pt_wrdata = '0;
    pt_wren   = 1'b0;
    unique case (1'b1)
      st_init: begin
        sb_we    = 1'b1;
        sb_waddr = i;
        sb_wdata = i;
      end
      st_swap: begin
        case (step)
          4'd0: sb_raddr = (state == ST_KSA) ? i : i + 8'd1;
          4'd2: sb_raddr = j;
          4'd4: begin
            sb_we    = 1'b1;
            sb_waddr = i;
            sb_wdata = sj;
          end
          4'd5: begin
            sb_we    = 1'b1;
            sb_waddr = j;
            sb_wdata = si;
          end
          default: ;
        endcase
      end
      st_len: begin
        if (step == 4'd1) begin
          pt_wren   = 1'b1;
          pt_wrdata = ct_rddata;
        end
      end
      st_prga: begin
        case (step)
          4'd1: sb_raddr = i;
          4'd3: sb_raddr = j;
          4'd5: begin
            sb_we    = 1'b1;
            sb_waddr = i;
            sb_wdata = sj;
          end
          4'd6: begin
            sb_we    = 1'b1;
            sb_waddr = j;
            sb_wdata = si;
          end
          4'd7: begin
            sb_raddr = si + sj;
            ct_addr  = k;
          end
          4'd8: begin
            pt_addr   = k;
            pt_wrdata = ct_rddata ^ sb_rd;
            pt_wren   = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      step  <= '0;
      i     <= '0;
      j     <= '0;
      k     <= '0;
      len   <= '0;
      si    <= '0;
      sj    <= '0;
      kidx  <= '0;
      dcnt  <= '0;
      key_r <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (en) begin
            key_r <= key;
            i     <= '0;
            j     <= '0;
            step  <= '0;
            state <= ST_INIT;
          end
        end
        ST_INIT: begin
          i <= i + 8'd1;
          if (i == 8'hff) begin
            j     <= '0;
            kidx  <= '0;
            step  <= '0;
            state <= ST_KSA;
          end
        end
        ST_KSA: begin
          step <= (step == KSA_LAST) ? 4'd0 : step + 4'd1;
          case (step)
            4'd1: begin
              si <= sb_rd;
              j  <= j + sb_rd + kb;
            end
            4'd3: sj <= sb_rd;
            4'd5: begin
              i    <= i + 8'd1;
              kidx <= (kidx == KEY_LAST) ? 5'd0 : kidx + 5'd1;
              if (i == 8'hff)
                state <= ST_LEN;
            end
            default: ;
          endcase
        end
        ST_LEN: begin
          if (step == 4'd0) begin
            step <= 4'd1;
          end else begin
            step <= '0;
            len  <= ct_rddata;
            i    <= '0;
            j    <= '0;
            k    <= 8'd1;
            if (DROP_N > 0)
              state <= ST_DROP;
            else if (ct_rddata == 8'd0)
              state <= ST_DONE;
            else
              state <= ST_PRGA;
          end
        end
        ST_DROP: begin
          step <= (step == DRP_LAST) ? 4'd0 : step + 4'd1;
          case (step)
            4'd0: i <= i + 8'd1;
            4'd1: begin
              si <= sb_rd;
              j  <= j + sb_rd;
            end
            4'd3: sj <= sb_rd;
            4'd5: begin
              if (dcnt == DROP_LAST) begin
                dcnt  <= '0;
                state <= (len == 8'd0) ? ST_DONE : ST_PRGA;
              end else begin
                dcnt <= dcnt + 12'd1;
              end
            end
            default: ;
          endcase
        end
        ST_PRGA: begin
          step <= (step == PRG_LAST) ? 4'd0 : step + 4'd1;
          case (step)
            4'd0: i <= i + 8'd1;
            4'd2: begin
              si <= sb_rd;
              j  <= j + sb_rd;
            end
            4'd4: sj <= sb_rd;
            4'd8: begin
              k <= k + 8'd1;
              if (k == len)
                state <= ST_DONE;
            end
            default: ;
          endcase
        end
        ST_DONE: begin
          step  <= '0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arc4_param.sv
// Bench for arc4_param: directed runs with random data, checked
// against a plain-arithmetic RC4-drop model.
module tb_arc4_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic en0 = 1'b0, en1 = 1'b0;
  logic [23:0]  key0 = '0;
  logic [127:0] key1 = '0;

  logic       rdy0, rdy1, pt_wren0, pt_wren1;
  logic [7:0] ct_addr0, ct_rd0, pt_addr0, pt_rd0, pt_wd0;
  logic [7:0] ct_addr1, ct_rd1, pt_addr1, pt_rd1, pt_wd1;

  arc4_param #(.KEY_BYTES(3), .DROP_N(0)) u0 (
    .clk(clk), .rst(rst), .en(en0), .rdy(rdy0), .key(key0),
    .ct_addr(ct_addr0), .ct_rddata(ct_rd0),
    .pt_addr(pt_addr0), .pt_rddata(pt_rd0),
    .pt_wrdata(pt_wd0), .pt_wren(pt_wren0)
  );

  arc4_param #(.KEY_BYTES(16), .DROP_N(768)) u1 (
    .clk(clk), .rst(rst), .en(en1), .rdy(rdy1), .key(key1),
    .ct_addr(ct_addr1), .ct_rddata(ct_rd1),
    .pt_addr(pt_addr1), .pt_rddata(pt_rd1),
    .pt_wrdata(pt_wd1), .pt_wren(pt_wren1)
  );

  logic [7:0] ct0 [256], pt0 [256], ct1 [256], pt1 [256];
  logic clr0 = 1'b0, clr1 = 1'b0;
  int wc0 = 0, wc1 = 0, dbl = 0;
  logic prev0 = 1'b0, prev1 = 1'b0;

  always @(posedge clk) begin
    ct_rd0 <= ct0[ct_addr0];
    pt_rd0 <= pt0[pt_addr0];
    ct_rd1 <= ct1[ct_addr1];
    pt_rd1 <= pt1[pt_addr1];
    if (clr0)
      for (int a = 0; a < 256; a++) pt0[a] <= 8'hAA;
    else if (pt_wren0)
      pt0[pt_addr0] <= pt_wd0;
    if (clr1)
      for (int a = 0; a < 256; a++) pt1[a] <= 8'hAA;
    else if (pt_wren1)
      pt1[pt_addr1] <= pt_wd1;
    if (pt_wren0) wc0 <= wc0 + 1;
    if (pt_wren1) wc1 <= wc1 + 1;
    if ((pt_wren0 && prev0) || (pt_wren1 && prev1)) dbl <= dbl + 1;
    prev0 <= pt_wren0;
    prev1 <= pt_wren1;
  end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [7:0] mkey [32];
  logic [7:0] mct [256], mpt [256];
  logic [7:0] vec_ct [10], vec_pt [10];

  // RC4-drop[drop] on mct with mkey[0..klen-1], result into mpt.
  task automatic model(input int klen, input int drop);
    int s [256];
    int a, b, t, ks, l;
    for (int x = 0; x < 256; x++) s[x] = x;
    b = 0;
    for (int x = 0; x < 256; x++) begin
      b = (b + s[x] + int'(mkey[x % klen])) % 256;
      t = s[x]; s[x] = s[b]; s[b] = t;
    end
    a = 0; b = 0;
    l = int'(mct[0]);
    mpt[0] = mct[0];
    for (int n = 0; n < drop + l; n++) begin
      a = (a + 1) % 256;
      b = (b + s[a]) % 256;
      t = s[a]; s[a] = s[b]; s[b] = t;
      ks = s[(s[a] + s[b]) % 256];
      if (n >= drop)
        mpt[n - drop + 1] = mct[n - drop + 1] ^ 8'(ks);
    end
  endtask

  task automatic run0(input logic [23:0] k, input bit tog,
                      output int lat, output int wcount);
    int w0;
    for (int a = 0; a < 256; a++) ct0[a] = mct[a];
    @(negedge clk); clr0 = 1'b1;
    @(negedge clk); clr0 = 1'b0;
    w0 = wc0;
    key0 = k;
    en0 = 1'b1;
    @(posedge clk); #1;
    en0 = 1'b0;
    chk("rdy_low_after_start", rdy0, 1'b0);
    lat = 0;
    while (!rdy0 && lat < 20000) begin
      if (tog) begin
        en0 = ~en0;
        key0 = ~key0;
      end
      @(posedge clk); #1;
      lat++;
    end
    en0 = 1'b0;
    wcount = wc0 - w0;
  endtask

  task automatic check_pt0(input string tag, input int l);
    for (int x = 0; x <= l; x++) chk(tag, pt0[x], mpt[x]);
    if (l < 255) chk({tag, "_untouched"}, pt0[l + 1], 8'hAA);
  endtask

  int lat, wcnt, l;
  logic [23:0] rk;

  initial begin
    vec_ct = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    vec_pt = '{8'h09, 8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
    for (int a = 0; a < 256; a++) begin
      ct0[a] = '0; ct1[a] = '0; mct[a] = '0;
    end

    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy0", rdy0, 1'b1);
    chk("rst_wren0", pt_wren0, 1'b0);
    chk("rst_ct_addr0", ct_addr0, 8'h00);
    chk("rst_pt_addr0", pt_addr0, 8'h00);
    chk("rst_pt_wd0", pt_wd0, 8'h00);
    chk("rst_rdy1", rdy1, 1'b1);
    chk("rst_wren1", pt_wren1, 1'b0);
    @(negedge clk); rst = 1'b0;

    // Known "Key"/"Plaintext" vector.
    mkey[0] = 8'h4B; mkey[1] = 8'h65; mkey[2] = 8'h79;
    for (int a = 0; a < 10; a++) mct[a] = vec_ct[a];
    run0(24'h4B6579, 1'b0, lat, wcnt);
    chk("vec_latency", lat, 1876);
    chk("vec_wren_count", wcnt, 10);
    for (int x = 0; x < 10; x++) chk("vec_pt", pt0[x], vec_pt[x]);

    // Empty message.
    mct[0] = 8'h00;
    for (int a = 1; a < 256; a++) mct[a] = 8'($urandom);
    model(3, 0);
    run0(24'h4B6579, 1'b0, lat, wcnt);
    chk("len0_latency", lat, 1795);
    chk("len0_wren_count", wcnt, 1);
    check_pt0("len0_pt", 0);

    // Maximum-length message.
    mkey[0] = 8'h00; mkey[1] = 8'h00; mkey[2] = 8'h18;
    mct[0] = 8'd255;
    for (int a = 1; a < 256; a++) mct[a] = 8'($urandom);
    model(3, 0);
    run0(24'h000018, 1'b0, lat, wcnt);
    chk("len255_latency", lat, 1795 + 9 * 255);
    chk("len255_wren_count", wcnt, 256);
    check_pt0("len255_pt", 255);

    // Reset in the middle of KSA, then rst+en together.
    key0 = 24'h4B6579;
    @(negedge clk); en0 = 1'b1;
    @(negedge clk); en0 = 1'b0;
    repeat (400) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_rdy", rdy0, 1'b1);
    chk("midrst_wren", pt_wren0, 1'b0);
    chk("midrst_pt_addr", pt_addr0, 8'h00);
    @(negedge clk); en0 = 1'b1;
    @(posedge clk); #1;
    chk("rst_beats_en", rdy0, 1'b1);
    @(negedge clk); rst = 1'b0; en0 = 1'b0;
    @(posedge clk); #1;
    chk("idle_after_rst", rdy0, 1'b1);

    mkey[0] = 8'h4B; mkey[1] = 8'h65; mkey[2] = 8'h79;
    for (int a = 0; a < 256; a++) mct[a] = '0;
    for (int a = 0; a < 10; a++) mct[a] = vec_ct[a];
    run0(24'h4B6579, 1'b0, lat, wcnt);
    chk("rerun_latency", lat, 1876);
    for (int x = 0; x < 10; x++) chk("rerun_pt", pt0[x], vec_pt[x]);

    // en and key wiggled throughout a run must not disturb it.
    rk = 24'($urandom);
    mkey[0] = rk[23:16]; mkey[1] = rk[15:8]; mkey[2] = rk[7:0];
    l = $urandom_range(40, 1);
    mct[0] = 8'(l);
    for (int a = 1; a < 256; a++) mct[a] = 8'($urandom);
    model(3, 0);
    run0(rk, 1'b1, lat, wcnt);
    chk("tog_latency", lat, 1795 + 9 * l);
    chk("tog_wren_count", wcnt, l + 1);
    check_pt0("tog_pt", l);

    // 16-byte key with RC4-drop768, 64-byte message.
    for (int b = 0; b < 16; b++) begin
      mkey[b] = 8'($urandom);
      key1[127 - 8 * b -: 8] = mkey[b];
    end
    mct[0] = 8'd64;
    for (int a = 1; a < 256; a++) mct[a] = 8'($urandom);
    model(16, 768);
    for (int a = 0; a < 256; a++) ct1[a] = mct[a];
    @(negedge clk); clr1 = 1'b1;
    @(negedge clk); clr1 = 1'b0;
    wcnt = wc1;
    en1 = 1'b1;
    @(posedge clk); #1;
    en1 = 1'b0;
    chk("drop_rdy_low", rdy1, 1'b0);
    lat = 0;
    while (!rdy1 && lat < 20000) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("drop_latency", lat, 1795 + 6 * 768 + 9 * 64);
    chk("drop_wren_count", wc1 - wcnt, 65);
    for (int x = 0; x <= 64; x++) chk("drop_pt", pt1[x], mpt[x]);
    chk("drop_untouched", pt1[65], 8'hAA);

    chk("no_back_to_back_wren", dbl, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
